// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped write-through cache.
// Optional build macro CACHE_PERF_EN (used by cache.sv) adds hit/miss counters.
package cache_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MASK_W     = 4;
    localparam int LINE_WORDS = 16;
    localparam int OFFSET_W   = 4;
    localparam int BYTE_W     = 2;
    localparam int LINE_LSB   = OFFSET_W + BYTE_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MREQ   = 3'd2,
        REFILL = 3'd3,
        WRITE  = 3'd4,
        RESP   = 3'd5
    } state_e;

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int num_lines);
        return ADDR_W - LINE_LSB - $clog2(num_lines);
    endfunction

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] new_word,
                                                      input logic [MASK_W-1:0] mask);
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < MASK_W; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage for the cache: byte-masked word writes, combinational read.
module cache_array
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     idx,
    input  logic [OFFSET_W-1:0]  rd_off,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [DATA_W-1:0]    rd_data,
    input  logic                 wr_en,
    input  logic [OFFSET_W-1:0]  wr_off,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [MASK_W-1:0]    wr_mask,
    input  logic                 fill_en,
    input  logic [TAG_W-1:0]     fill_tag,
    input  logic                 inv_en
);

    logic [NUM_LINES-1:0]          valid_q;
    logic [NUM_LINES-1:0]          valid_d;
    logic [TAG_W-1:0]              tag_q  [NUM_LINES];
    logic [DATA_W-1:0]             data_q [NUM_LINES*LINE_WORDS];
    logic [IDX_W+OFFSET_W-1:0]     rd_addr_s;
    logic [IDX_W+OFFSET_W-1:0]     wr_addr_s;

    assign rd_addr_s = {idx, rd_off};
    assign wr_addr_s = {idx, wr_off};

    // Next valid bits: invalidate when a refill starts, validate when it completes.
    always_comb begin
        valid_d = valid_q;
        if (inv_en) begin
            valid_d[idx] = 1'b0;
        end else if (fill_en) begin
            valid_d[idx] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits are the only storage that needs reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= {NUM_LINES{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays, written without reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx] <= fill_tag;
        end
        if (wr_en) begin
            data_q[wr_addr_s] <= merge_bytes(data_q[wr_addr_s], wr_data, wr_mask);
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[rd_addr_s];

endmodule

// File: rtl/cache.sv
// Direct-mapped, write-through, no-write-allocate cache with 16-word line refill.
// Define CACHE_PERF_EN to add the hit_cnt/miss_cnt performance counter outputs.
module cache
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_mask,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        m_req_valid,
    output logic [31:0] m_req_addr,
    output logic [31:0] m_req_data,
    output logic [3:0]  m_req_mask,
    input  logic        m_resp_valid,
`ifdef CACHE_PERF_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    input  logic [31:0] m_resp_data
);

    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(NUM_LINES);

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    mask_q, mask_d;
    logic [3:0]    beat_q, beat_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          m_req_valid_q, m_req_valid_d;
    logic [31:0]   m_req_addr_q, m_req_addr_d;
    logic [31:0]   m_req_data_q, m_req_data_d;
    logic [3:0]    m_req_mask_q, m_req_mask_d;

    logic [IDX_W-1:0]    idx_s;
    logic [OFFSET_W-1:0] off_s;
    logic [TAG_W-1:0]    tag_s;
    logic                rd_valid_s;
    logic [TAG_W-1:0]    rd_tag_s;
    logic [31:0]         rd_data_s;
    logic                hit_s;
    logic                wr_en_s;
    logic [OFFSET_W-1:0] wr_off_s;
    logic [31:0]         wr_data_s;
    logic [3:0]          wr_mask_s;
    logic                fill_en_s;
    logic                inv_en_s;

    assign idx_s = addr_q[LINE_LSB +: IDX_W];
    assign off_s = addr_q[BYTE_W +: OFFSET_W];
    assign tag_s = addr_q[ADDR_W-1 -: TAG_W];
    assign hit_s = rd_valid_s && (rd_tag_s == tag_s);

    cache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .idx      (idx_s),
        .rd_off   (off_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .wr_en    (wr_en_s),
        .wr_off   (wr_off_s),
        .wr_data  (wr_data_s),
        .wr_mask  (wr_mask_s),
        .fill_en  (fill_en_s),
        .fill_tag (tag_s),
        .inv_en   (inv_en_s)
    );

    // Next-state, registered-output and array-control logic of the controller.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        mask_d        = mask_q;
        beat_d        = beat_q;
        resp_valid_d  = 1'b0;
        resp_data_d   = 32'h0000_0000;
        m_req_valid_d = m_req_valid_q;
        m_req_addr_d  = m_req_addr_q;
        m_req_data_d  = m_req_data_q;
        m_req_mask_d  = m_req_mask_q;
        wr_en_s       = 1'b0;
        wr_off_s      = off_s;
        wr_data_s     = data_q;
        wr_mask_s     = mask_q;
        fill_en_s     = 1'b0;
        inv_en_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    data_d  = req_data;
                    mask_d  = req_mask;
                    state_d = LOOKUP;
                end else begin
                    state_d = IDLE;
                end
            end
            LOOKUP: begin
                if (mask_q != 4'h0) begin
                    wr_en_s       = hit_s;
                    m_req_valid_d = 1'b1;
                    m_req_addr_d  = addr_q;
                    m_req_data_d  = data_q;
                    m_req_mask_d  = mask_q;
                    state_d       = WRITE;
                end else if (hit_s) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = rd_data_s;
                    state_d      = RESP;
                end else begin
                    m_req_valid_d = 1'b1;
                    m_req_addr_d  = {addr_q[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
                    m_req_data_d  = 32'h0000_0000;
                    m_req_mask_d  = 4'h0;
                    state_d       = MREQ;
                end
            end
            MREQ, WRITE: begin
                if (m_resp_valid) begin
                    m_req_valid_d = 1'b0;
                    m_req_addr_d  = 32'h0000_0000;
                    m_req_data_d  = 32'h0000_0000;
                    m_req_mask_d  = 4'h0;
                    if (state_q == MREQ) begin
                        // The line is invalid while its words are being overwritten.
                        inv_en_s = 1'b1;
                        beat_d   = 4'h0;
                        state_d  = REFILL;
                    end else begin
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            REFILL: begin
                if (m_resp_valid) begin
                    wr_en_s   = 1'b1;
                    wr_off_s  = beat_q;
                    wr_data_s = m_resp_data;
                    wr_mask_s = 4'hF;
                    beat_d    = beat_q + 4'h1;
                    if (beat_q == 4'hF) begin
                        // Word 15 is still on the bus; earlier words are already in the array.
                        fill_en_s    = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_data_d  = (off_s == 4'hF) ? m_resp_data : rd_data_s;
                        state_d      = RESP;
                    end else begin
                        state_d = REFILL;
                    end
                end else begin
                    state_d = REFILL;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d       = IDLE;
                m_req_valid_d = 1'b0;
                m_req_addr_d  = 32'h0000_0000;
                m_req_data_d  = 32'h0000_0000;
                m_req_mask_d  = 4'h0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            addr_q        <= 32'h0000_0000;
            data_q        <= 32'h0000_0000;
            mask_q        <= 4'h0;
            beat_q        <= 4'h0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= 32'h0000_0000;
            m_req_valid_q <= 1'b0;
            m_req_addr_q  <= 32'h0000_0000;
            m_req_data_q  <= 32'h0000_0000;
            m_req_mask_q  <= 4'h0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            mask_q        <= mask_d;
            beat_q        <= beat_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            m_req_valid_q <= m_req_valid_d;
            m_req_addr_q  <= m_req_addr_d;
            m_req_data_q  <= m_req_data_d;
            m_req_mask_q  <= m_req_mask_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign m_req_valid = m_req_valid_q;
    assign m_req_addr  = m_req_addr_q;
    assign m_req_data  = m_req_data_q;
    assign m_req_mask  = m_req_mask_q;

`ifdef CACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Each request is classified exactly once, in its LOOKUP cycle.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP) begin
            if (hit_s) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end else begin
            hit_cnt_d  = hit_cnt_q;
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache.sv
// Directed bench for cache: memory model/responder plus scoreboard queues for
// CPU responses and memory requests.
module tb_cache;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        m_req_valid;
    logic [31:0] m_req_addr;
    logic [31:0] m_req_data;
    logic [3:0]  m_req_mask;
    logic        m_resp_valid;
    logic [31:0] m_resp_data;
`ifdef CACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    cache #(.NUM_LINES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_mask     (req_mask),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .m_req_valid  (m_req_valid),
        .m_req_addr   (m_req_addr),
        .m_req_data   (m_req_data),
        .m_req_mask   (m_req_mask),
        .m_resp_valid (m_resp_valid),
`ifdef CACHE_PERF_EN
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
`endif
        .m_resp_data  (m_resp_data)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } mreq_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    mreq_t       mreq_q[$];
    logic [31:0] mem [0:2047];
    int          mreq_cnt = 0;
    int          phase = 0;
    int          fill_beats = 0;
    logic [10:0] fill_word;
    bit          drove_beat = 1'b0;
    bit          gap_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory responder: accepts each request at once, write-through updates the
    // model, refills stream 16 beats with one idle cycle before beat 5.
    initial begin
        mreq_t e;
        m_resp_valid = 1'b0;
        m_resp_data  = 32'h0;
        for (int i = 0; i < 2048; i++) mem[i] = i;
        forever begin
            @(negedge clk);
            if (!rst) begin
                phase = 0; fill_beats = 0; drove_beat = 1'b0;
                m_resp_valid = 1'b0; m_resp_data = 32'h0;
            end else if (phase == 0) begin
                m_resp_valid = 1'b0;
                m_resp_data  = 32'h0;
                if (m_req_valid) begin
                    mreq_cnt++;
                    if (mreq_q.size() == 0) begin
                        check32("mreq_unexpected", m_req_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = mreq_q.pop_front();
                        check32("mreq_addr", m_req_addr, e.addr);
                        check32("mreq_data", m_req_data, e.data);
                        check32("mreq_mask", {28'h0, m_req_mask}, {28'h0, e.mask});
                    end
                    if (m_req_mask != 4'h0) begin
                        for (int b = 0; b < 4; b++)
                            if (m_req_mask[b]) mem[m_req_addr[12:2]][8*b +: 8] = m_req_data[8*b +: 8];
                    end else begin
                        phase = 1; fill_beats = 0; drove_beat = 1'b0; gap_done = 1'b0;
                        fill_word = m_req_addr[12:2];
                    end
                    m_resp_valid = 1'b1;
                end else begin
                    check32("mreq_idle_fields", m_req_addr | m_req_data | {28'h0, m_req_mask}, 32'h0);
                end
            end else begin
                if (drove_beat) fill_beats++;
                if (fill_beats == 16) begin
                    phase = 0; drove_beat = 1'b0;
                    m_resp_valid = 1'b0; m_resp_data = 32'h0;
                end else if (fill_beats == 5 && !gap_done) begin
                    gap_done = 1'b1; drove_beat = 1'b0;
                    m_resp_valid = 1'b0; m_resp_data = 32'hDEAD_BEEF;
                end else begin
                    drove_beat = 1'b1;
                    m_resp_valid = 1'b1;
                    m_resp_data = mem[fill_word + 11'(fill_beats)];
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check32({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
        check32({tag, "_resp_data"}, resp_data, 32'h0);
        check32({tag, "_m_req_valid"}, {31'h0, m_req_valid}, 32'h0);
        check32({tag, "_m_req_addr"}, m_req_addr, 32'h0);
        check32({tag, "_m_req_data"}, m_req_data, 32'h0);
        check32({tag, "_m_req_mask"}, {28'h0, m_req_mask}, 32'h0);
    endtask

    // miss=1 on a read expects a line refill; writes always expect one write-through.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic [31:0] exp, input bit miss, input int exp_lat);
        int n0, cyc, exp_n;
        bit got;
        logic [31:0] e;
        n0 = mreq_cnt;
        exp_n = 0;
        if (m != 4'h0) begin
            mreq_q.push_back('{addr: a, data: d, mask: m}); exp_n = 1;
        end else if (miss) begin
            mreq_q.push_back('{addr: {a[31:6], 6'h0}, data: 32'h0, mask: 4'h0}); exp_n = 1;
        end
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_data = d; req_mask = m;
        exp_q.push_back(exp);
        cyc = 0; got = 1'b0;
        while (cyc < 300 && !got) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) got = 1'b1;
        end
        check32("resp_seen", {31'h0, got}, 32'h1);
        e = exp_q.pop_front();
        if (got) check32("resp_data", resp_data, e);
        req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0; req_mask = 4'h0;
        check32("mreq_count", mreq_cnt - n0, exp_n);
        if (exp_lat >= 0) check32("resp_latency", cyc, exp_lat);
        if (miss && m == 4'h0) check32("refill_beats", fill_beats, 16);
        @(negedge clk);
        check32("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        int cyc;
        rst = 1'b0;
        req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0; req_mask = 4'h0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;

        do_req(32'h0000_0000, 32'h0, 4'h0, 32'h0000_0000, 1'b1, -1);
        do_req(32'h0000_0004, 32'h0, 4'h0, 32'h0000_0001, 1'b0, 2);
        do_req(32'h0000_0400, 32'h0, 4'h0, 32'd256,       1'b1, -1);
        do_req(32'h0000_0000, 32'h0, 4'h0, 32'h0000_0000, 1'b1, -1);
        do_req(32'h0000_0008, 32'hAABB_CCDD, 4'h3, 32'h0, 1'b0, -1);
        do_req(32'h0000_0008, 32'h0, 4'h0, 32'h0000_CCDD, 1'b0, 2);
        do_req(32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0, 1'b1, -1);
        do_req(32'h0000_1000, 32'h0, 4'h0, 32'h1234_5678, 1'b1, -1);
        do_req(32'h0000_007C, 32'h0, 4'h0, 32'd31,        1'b1, -1);
        do_req(32'h0000_007C, 32'h0, 4'h0, 32'd31,        1'b0, 2);

        // Reset in the middle of a refill.
        mreq_q.push_back('{addr: 32'h0000_0840, data: 32'h0, mask: 4'h0});
        exp_q.push_back(32'd528);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0840; req_data = 32'h0; req_mask = 4'h0;
        cyc = 0;
        while (!(phase == 1 && fill_beats >= 7) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check32("rst_beat7_reached", {31'h0, (phase == 1 && fill_beats >= 7)}, 32'h1);
        rst = 1'b0;
        #1;
        check_outputs_zero("midrefill_reset");
        req_valid = 1'b0; req_addr = 32'h0;
        exp_q.delete();
        mreq_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_req(32'h0000_0840, 32'h0, 4'h0, 32'd528, 1'b1, -1);
        do_req(32'h0000_0844, 32'h0, 4'h0, 32'd529, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, meaning the number of direct-mapped lines (power of two, minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: CPU request valid; the requester holds it and its fields until resp_valid.
REQ-005 SHALL have ports req_addr, req_data and req_mask, inputs, 32/32/4 bits: byte address, write data, and byte-enable mask; mask 0 means read, nonzero means write.
REQ-006 SHALL have ports resp_valid and resp_data, outputs, 1/32 bits: a one-cycle completion pulse and the read data.
REQ-007 SHALL have ports m_req_valid, m_req_addr, m_req_data and m_req_mask, outputs, 1/32/32/4 bits: the memory request.
REQ-008 SHALL have ports m_resp_valid and m_resp_data, inputs, 1/32 bits: memory ready/beat strobe and the beat data.

Function
REQ-009 SHALL be direct-mapped with 64-byte lines of 16 words; offset = addr[5:2]; index = next log2(NUM_LINES) bits; tag = the remaining upper bits; addr[1:0] ignored.
REQ-010 SHALL use FSM states IDLE, LOOKUP, MREQ, REFILL, WRITE and RESP.
REQ-011 IDLE SHALL sample req_valid; if high, latch addr/data/mask and go to LOOKUP.
REQ-012 LOOKUP on a read hit SHALL capture the word and go to RESP, so resp_valid is high 2 cycles after the accepting edge.
REQ-013 LOOKUP on a read miss SHALL go to MREQ.
REQ-014 MREQ SHALL drive m_req_valid=1, m_req_addr = the request address with bits [5:0] cleared, and m_req_mask=0.
REQ-015 MREQ SHALL treat the request as accepted on an edge where m_req_valid and m_resp_valid are both high, then go to REFILL.
REQ-016 REFILL SHALL write m_resp_data into words 0..15 in order, one word per cycle in which m_resp_valid is high; idle cycles are allowed.
REQ-017 After beat 15, REFILL SHALL set the tag and valid bit, select the requested word, and go to RESP.
REQ-018 LOOKUP on any write SHALL go to WRITE; on a write hit, bytes with mask bit set SHALL be merged into the cached word.
REQ-019 A write miss SHALL not allocate a line.
REQ-020 WRITE SHALL drive m_req_valid=1 with req_addr, req_data and req_mask (write-through); acceptance uses the same rule as MREQ, then the FSM goes to RESP.
REQ-021 RESP SHALL assert resp_valid for exactly one cycle with resp_data = read word (0 for writes), then return to IDLE; req_valid is ignored in RESP.
REQ-022 m_req_addr, m_req_data and m_req_mask SHALL be 0 whenever m_req_valid is 0; m_resp_valid SHALL be ignored outside MREQ, WRITE and REFILL.

Reset
REQ-023 Reset SHALL force IDLE, clear all valid bits, and drive all outputs to 0.
REQ-024 Reset during MREQ or REFILL SHALL abort the operation and leave the line invalid.
REQ-025 Data and tag arrays SHALL not need reset.

Configuration
REQ-026 With CACHE_PERF_EN defined, the block SHALL add 32-bit outputs hit_cnt and miss_cnt, each incremented once per request classified in LOOKUP, wrapping at 2^32 and cleared by reset.
REQ-027 Without CACHE_PERF_EN, those ports and counters SHALL be absent.

Structure
REQ-028 Package cache_pkg SHALL hold the FSM state enum, LINE_WORDS=16, OFFSET_W=4, and the width-derivation constants.
REQ-029 Sub-module cache_array SHALL hold the valid, tag and data storage, with word-granular byte-masked write and combinational read.

Verification
REQ-030 Memory preloaded mem[i]=i, reset released, read 0x0 -> one m_req_valid at addr 0x0 mask 0, 16 beats, then resp_data=0x0.
REQ-031 Then read 0x4 -> hit, no m_req_valid, resp_valid 2 cycles after accept, resp_data=0x1.
REQ-032 Read 0x400 with NUM_LINES=16 (same index, new tag) -> refill from 0x400, resp_data=mem[256]; a following read of 0x0 misses again.
REQ-033 Write 0x8 data 0xAABBCCDD mask 0x3 on hit -> m_req addr 0x8 mask 0x3; a subsequent read of 0x8 returns 0x0000CCDD.
REQ-034 Write miss to 0x1000 -> write-through only; a later read of 0x1000 performs a refill.
REQ-035 Assert rst at refill beat 7 -> all outputs 0 immediately; re-reading the same address refills fully.
